enemy_fire_scheduler: RTL and testbench
=======================================

# enemy_fire_scheduler

Sequences enemy missile launches for the invader array. Once per fire interval it chooses a shooting column, alternating between the column above the player ("aimed") and an LFSR-chosen column ("random"). It then finds the lowest live enemy in that column, or in the next live column, and assigns the shot to a free enemy-missile slot with a one-cycle fire pulse. It sits between the enemy-array status logic and a bank of NUM_SLOTS enemy-missile movers, which own flight and collision.

## Interface
- NUM_SLOTS, 3, number of missile mover slots (1..4)
- FIRE_INTERVAL, 8'd60, frames between launch attempts (2..255)
- vsync  in  1  clock; frame-rate tick, all state changes on posedge
- reset  in  1  synchronous, active-high
- state  in  4  game state; scheduler runs only when state == 4'd1
- playerX  in  10  player left X coordinate
- enemy_status  in  [9:0][5:0]  alive bits; [c][r] = column c, row r, row 5 lowest on screen
- enemy_offset  in  10  X offset of enemy array
- slot_busy  in  NUM_SLOTS  1 = slot's missile exists
- fire  out  1  one-cycle launch pulse
- fire_slot  out  2  slot index accompanying fire
- fireX  out  10  launch X, valid while fire = 1
- fireY  out  10  launch Y, valid while fire = 1

## Operation
- FSM states: IDLE, SELECT, SEARCH, SLOT.
- Reset values: FSM = IDLE, timer = 0, aim_next = 1, lfsr = 8'hA5, fire = 0, fire_slot = 0, fireX = 0, fireY = 0.
- LFSR: 8-bit Fibonacci. Each cycle except reset, lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. It advances in every game state.
- state != 4'd1 (checked after reset, with priority over FSM): FSM <= IDLE, timer <= 0, fire <= 0. aim_next and the lfsr are unaffected.
- IDLE: timer increments. When timer == FIRE_INTERVAL-1: timer <= 0, go to SELECT.
- SELECT:
  - If aim_next, start column = playerX[9:6], clamped to 9 when > 9.
  - Otherwise, start column = lfsr[3:0], minus 10 when ≥ 10.
  - Set cur = start, cnt = 0, toggle aim_next, go to SEARCH.
- SEARCH (one column per cycle):
  - If enemy_status[cur] != 0:
    - r = highest set bit of enemy_status[cur].
    - fireY <= 64 + 32*r.
    - fireX <= {cur[3:0],6'b0} + enemy_offset + 16, mod 2^10.
    - Go to SLOT.
  - Else if cnt == 9: go to IDLE with no fire (array cleared).
  - Else: cur <= (cur == 9) ? 0 : cur+1, cnt++.
- SLOT:
  - If any slot_busy bit is 0: fire_slot <= lowest free index, fire <= 1, go to IDLE.
  - Otherwise stay in SLOT with timer frozen at 0. fireX and fireY are held.
- fire deasserts on the cycle after it asserts. fireX, fireY and fire_slot hold until the next launch.
- Column enemy_status is sampled live each SEARCH cycle. Kills during the search are honoured.

## Timing
- Best case, measured in posedges after timer reaches FIRE_INTERVAL-1: SELECT +1, SEARCH +2, SLOT +3, fire high after edge +4 for exactly one cycle.
- Each empty column scanned adds 1 cycle. The worst case is 10 SEARCH cycles, then a return to IDLE.
- Launch period when slots are free and the start column is live: FIRE_INTERVAL + 3 cycles.
- Mover contract: a slot must raise slot_busy no later than the cycle after fire. The scheduler never issues two fires closer than FIRE_INTERVAL+3 cycles apart.
- Reset mid-operation: all registers return to reset values on the next edge, and fire is never asserted on that edge.

## Test plan
- Aimed hit (FIRE_INTERVAL = 4, all enemies alive, playerX = 200, enemy_offset = 20, slot_busy = 0) -> first fire 4 edges after timer = 3, fire_slot = 0, fireX = 228, fireY = 224; fire high for 1 cycle only.
- Clamp and wrap:
  - Stimulus: playerX = 700, column 9 empty, column 0 has only row 2, offset = 0.
  - Required: fireX = 16, fireY = 128, and fire one cycle later than the best case.
- Slots full:
  - Stimulus: slot_busy = 3'b111 at SLOT entry.
  - Required: FSM stays in SLOT with no fire and timer = 0.
  - Then set slot_busy = 3'b101: fire on the next edge with fire_slot = 1.
- Alternation: two consecutive launches, all alive -> the first comes from the aimed column. The second start column equals the lfsr[3:0] (mod 10) value sampled in its SELECT cycle.
- Empty array: enemy_status = 0 -> 10 SEARCH cycles, return to IDLE, no fire, next attempt FIRE_INTERVAL later.
- Interrupts:
  - Drop state to 4'd2 during SEARCH -> IDLE, no fire, timer 0.
  - Assert reset during SLOT -> all outputs at reset values, lfsr = 8'hA5.

Source files
------------

// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler
// Picks when and from where an enemy missile is launched. Every FIRE_INTERVAL
// frames it chooses a start column. The choice alternates between the column
// above the player and an LFSR-derived column. It then walks the columns,
// one per frame, until it finds a live one. The shot leaves from the lowest
// live enemy in that column and goes to the lowest-numbered free missile slot.
//
// Ports:
//   vsync        frame tick, the only clock
//   reset        synchronous, active-high
//   state        game state; the scheduler only runs in state 1
//   playerX      player left X
//   enemy_status alive bits, [col][row], row 5 is lowest on screen
//   enemy_offset X offset of the enemy array
//   slot_busy    per-slot "missile in flight" flags from the movers
//   fire         one-cycle launch pulse
//   fire_slot    slot index for the launch (held until the next launch)
//   fireX/fireY  launch coordinates (held until the next launch)
module enemy_fire_scheduler #(
  parameter int         NUM_SLOTS     = 3,
  parameter logic [7:0] FIRE_INTERVAL = 8'd60
) (
  input  logic                 vsync,
  input  logic                 reset,
  input  logic [3:0]           state,
  input  logic [9:0]           playerX,
  input  logic [9:0][5:0]      enemy_status,
  input  logic [9:0]           enemy_offset,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  output logic                 fire,
  output logic [1:0]           fire_slot,
  output logic [9:0]           fireX,
  output logic [9:0]           fireY
);

  typedef enum logic [1:0] {IDLE, SELECT, SEARCH, SLOT} fsm_t;

  fsm_t       fsm, fsm_nxt;
  logic [7:0] timer, timer_nxt;
  logic       aim_next, aim_nxt;
  logic [7:0] lfsr, lfsr_nxt;
  logic [3:0] cur, cur_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       fire_nxt;
  logic [1:0] slot_nxt;
  logic [9:0] x_nxt, y_nxt;

  // Only the column index bits of playerX matter.
  logic unused_playerx;
  assign unused_playerx = ^playerX[5:0];

  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // Start-column candidates: aimed column clamped to 9, LFSR column folded into 0..9.
  logic [3:0] aim_col, rnd_col;
  assign aim_col = (playerX[9:6] > 4'd9) ? 4'd9 : playerX[9:6];
  assign rnd_col = (lfsr[3:0] >= 4'd10) ? (lfsr[3:0] - 4'd10) : lfsr[3:0];

  // Lowest live enemy in the column under inspection = highest set row bit.
  logic [5:0] col_bits;
  logic [2:0] row;
  assign col_bits = enemy_status[cur];

  always_comb begin
    row = 3'd0;
    for (int i = 0; i < 6; i++)
      if (col_bits[i]) row = 3'(i);
  end

  // Lowest free slot. Scanning downward lets the lowest index win.
  logic       any_free;
  logic [1:0] free_idx;

  always_comb begin
    any_free = 1'b0;
    free_idx = 2'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (!slot_busy[i]) begin
        any_free = 1'b1;
        free_idx = 2'(i);
      end
  end

  always_comb begin
    fsm_nxt   = fsm;
    timer_nxt = timer;
    aim_nxt   = aim_next;
    cur_nxt   = cur;
    cnt_nxt   = cnt;
    fire_nxt  = 1'b0;
    slot_nxt  = fire_slot;
    x_nxt     = fireX;
    y_nxt     = fireY;
    if (state != 4'd1) begin
      // Outside normal play: abandon any attempt and restart the interval later.
      fsm_nxt   = IDLE;
      timer_nxt = 8'd0;
    end else begin
      case (fsm)
        IDLE: begin
          if (timer == FIRE_INTERVAL - 8'd1) begin
            timer_nxt = 8'd0;
            fsm_nxt   = SELECT;
          end else begin
            timer_nxt = timer + 8'd1;
          end
        end
        SELECT: begin
          cur_nxt = aim_next ? aim_col : rnd_col;
          cnt_nxt = 4'd0;
          aim_nxt = ~aim_next;
          fsm_nxt = SEARCH;
        end
        SEARCH: begin
          if (col_bits != 6'd0) begin
            y_nxt   = 10'd64 + {2'b00, row, 5'b00000};
            x_nxt   = {cur, 6'b000000} + enemy_offset + 10'd16;
            fsm_nxt = SLOT;
          end else if (cnt == 4'd9) begin
            // Every column has been inspected: the array is empty.
            fsm_nxt = IDLE;
          end else begin
            cur_nxt = (cur == 4'd9) ? 4'd0 : cur + 4'd1;
            cnt_nxt = cnt + 4'd1;
          end
        end
        SLOT: begin
          timer_nxt = 8'd0;
          if (any_free) begin
            slot_nxt = free_idx;
            fire_nxt = 1'b1;
            fsm_nxt  = IDLE;
          end
        end
        default: fsm_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge vsync) begin
    if (reset) begin
      fsm       <= IDLE;
      timer     <= 8'd0;
      aim_next  <= 1'b1;
      lfsr      <= 8'hA5;
      cur       <= 4'd0;
      cnt       <= 4'd0;
      fire      <= 1'b0;
      fire_slot <= 2'd0;
      fireX     <= 10'd0;
      fireY     <= 10'd0;
    end else begin
      fsm       <= fsm_nxt;
      timer     <= timer_nxt;
      aim_next  <= aim_nxt;
      lfsr      <= lfsr_nxt;
      cur       <= cur_nxt;
      cnt       <= cnt_nxt;
      fire      <= fire_nxt;
      fire_slot <= slot_nxt;
      fireX     <= x_nxt;
      fireY     <= y_nxt;
    end
  end

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
module tb_enemy_fire_scheduler;
  localparam int F  = 4;
  localparam int NS = 3;

  logic            vsync = 1'b0;
  logic            reset = 1'b1;
  logic [3:0]      gstate = 4'd1;
  logic [9:0]      playerX = '0;
  logic [9:0][5:0] enemy_status = '0;
  logic [9:0]      enemy_offset = '0;
  logic [NS-1:0]   slot_busy = '0;
  logic            fire;
  logic [1:0]      fire_slot;
  logic [9:0]      fireX, fireY;

  int checks = 0;
  int errors = 0;

  enemy_fire_scheduler #(.NUM_SLOTS(NS), .FIRE_INTERVAL(8'(F))) dut (
    .vsync(vsync), .reset(reset), .state(gstate), .playerX(playerX),
    .enemy_status(enemy_status), .enemy_offset(enemy_offset),
    .slot_busy(slot_busy), .fire(fire), .fire_slot(fire_slot),
    .fireX(fireX), .fireY(fireY)
  );

  always #5 vsync = ~vsync;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [9:0]      px;
    logic [9:0]      off;
    logic [9:0][5:0] st;
    logic [2:0]      sb;
    logic [9:0]      ex;
    logic [9:0]      ey;
    logic [1:0]      eslot;
    int              extra;
  } vec_t;

  vec_t tv[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_after(input int n);
    logic [7:0] l = 8'hA5;
    for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction

  function automatic int aim_col(input logic [9:0] px);
    int c = int'(px) / 64;
    return (c > 9) ? 9 : c;
  endfunction

  function automatic int rnd_col(input int n);
    int c = int'(lfsr_after(n)) % 16;
    return (c >= 10) ? c - 10 : c;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge vsync); #1;
    reset = 1'b0;
  endtask

  task automatic edges(input int n);
    repeat (n) begin @(posedge vsync); #1; end
  endtask

  // Transaction-level prediction of one launch attempt started from IDLE with
  // timer 0. Inputs are held stable for the whole attempt.
  task automatic check_attempt(input string nm, input int start, output int used);
    int   j = -1;
    int   r = 0;
    int   x = 0;
    int   sl = -1;
    int   total;
    logic early = 1'b0;
    for (int k = 0; k < 10; k++) begin
      int c = (start + k) % 10;
      if (j < 0 && enemy_status[c] != 6'd0) begin
        j = k;
        for (int b = 0; b < 6; b++) if (enemy_status[c][b]) r = b;
        x = (c * 64 + int'(enemy_offset) + 16) % 1024;
      end
    end
    for (int i = NS - 1; i >= 0; i--) if (!slot_busy[i]) sl = i;
    total = (j >= 0) ? F + 3 + j : F + 11;
    for (int k = 1; k <= total; k++) begin
      @(posedge vsync); #1;
      if (k < total && fire) early = 1'b1;
    end
    chk({nm, " early_fire"}, early, 0);
    if (j >= 0) begin
      chk({nm, " fire"}, fire, 1);
      chk({nm, " fireX"}, fireX, x);
      chk({nm, " fireY"}, fireY, 64 + 32 * r);
      chk({nm, " slot"}, fire_slot, sl);
    end else begin
      chk({nm, " no_fire"}, fire, 0);
      chk({nm, " timer_idle"}, dut.timer, 0);
    end
    used = total;
  endtask

  initial begin
    int   n, used;
    logic aim;
    logic early;

    // Vector table: each entry is a fresh aimed attempt after reset.
    for (int i = 0; i < 5; i++) tv[i].st = '1;
    tv[0].px = 10'd200;  tv[0].off = 10'd20;   tv[0].sb = 3'b000;
    tv[0].ex = 10'd228;  tv[0].ey = 10'd224;   tv[0].eslot = 2'd0; tv[0].extra = 0;
    tv[1].px = 10'd700;  tv[1].off = 10'd0;    tv[1].sb = 3'b000;
    tv[1].st[9] = 6'd0;  tv[1].st[0] = 6'b000100;
    tv[1].ex = 10'd16;   tv[1].ey = 10'd128;   tv[1].eslot = 2'd0; tv[1].extra = 1;
    tv[2].px = 10'd10;   tv[2].off = 10'd1000; tv[2].sb = 3'b001;
    tv[2].st[0] = 6'b000011;
    tv[2].ex = 10'd1016; tv[2].ey = 10'd96;    tv[2].eslot = 2'd1; tv[2].extra = 0;
    tv[3].px = 10'd256;  tv[3].off = 10'd5;    tv[3].sb = 3'b011;
    tv[3].st[4] = 6'd0;  tv[3].st[5] = 6'd0;   tv[3].st[6] = 6'd0; tv[3].st[7] = 6'b100000;
    tv[3].ex = 10'd469;  tv[3].ey = 10'd224;   tv[3].eslot = 2'd2; tv[3].extra = 3;
    tv[4].px = 10'd1023; tv[4].off = 10'd1020; tv[4].sb = 3'b110;
    tv[4].st[9] = 6'b000001;
    tv[4].ex = 10'd588;  tv[4].ey = 10'd64;    tv[4].eslot = 2'd0; tv[4].extra = 0;

    // Reset state.
    edges(2);
    chk("rst fire", fire, 0);
    chk("rst fire_slot", fire_slot, 0);
    chk("rst fireX", fireX, 0);
    chk("rst fireY", fireY, 0);
    chk("rst lfsr", dut.lfsr, 8'hA5);
    chk("rst timer", dut.timer, 0);

    for (int i = 0; i < 5; i++) begin
      playerX = tv[i].px; enemy_offset = tv[i].off;
      enemy_status = tv[i].st; slot_busy = tv[i].sb;
      do_reset();
      early = 1'b0;
      for (int k = 1; k < F; k++) begin
        @(posedge vsync); #1;
        if (fire) early = 1'b1;
      end
      chk("vec timer_top", dut.timer, F - 1);
      for (int k = 1; k <= 4 + tv[i].extra; k++) begin
        @(posedge vsync); #1;
        if (k < 4 + tv[i].extra && fire) early = 1'b1;
      end
      chk("vec early_fire", early, 0);
      chk("vec fire", fire, 1);
      chk("vec fireX", fireX, tv[i].ex);
      chk("vec fireY", fireY, tv[i].ey);
      chk("vec slot", fire_slot, tv[i].eslot);
      edges(1);
      chk("vec fire_one_cycle", fire, 0);
      chk("vec fireX_hold", fireX, tv[i].ex);
    end

    // Slots full, then one frees up.
    playerX = 10'd200; enemy_offset = 10'd20; enemy_status = '1; slot_busy = 3'b111;
    do_reset();
    edges(F + 3);
    early = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (fire || dut.timer != 8'd0) early = 1'b1;
      edges(1);
    end
    chk("full no_fire_timer0", early, 0);
    chk("full fireX_held", fireX, 228);
    slot_busy = 3'b101;
    edges(1);
    chk("full fire", fire, 1);
    chk("full slot", fire_slot, 1);

    // Reset while waiting in SLOT.
    slot_busy = 3'b111;
    do_reset();
    edges(F + 4);
    slot_busy = 3'b000;
    reset = 1'b1;
    edges(1);
    chk("rstslot fire", fire, 0);
    chk("rstslot fireX", fireX, 0);
    chk("rstslot fireY", fireY, 0);
    chk("rstslot slot", fire_slot, 0);
    chk("rstslot lfsr", dut.lfsr, 8'hA5);
    reset = 1'b0;

    // Empty array, then the next attempt uses the random column.
    enemy_status = '0; playerX = 10'd200; slot_busy = 3'b000;
    do_reset();
    check_attempt("empty", aim_col(playerX), used);
    enemy_status = '1;
    n = used;
    check_attempt("after_empty", rnd_col(n + F), used);

    // Leave play during SEARCH.
    enemy_status = '1;
    for (int c = 3; c <= 8; c++) enemy_status[c] = 6'd0;
    playerX = 10'd192;
    do_reset();
    edges(F + 2);
    gstate = 4'd2;
    edges(1);
    chk("intr fire", fire, 0);
    chk("intr timer", dut.timer, 0);
    early = 1'b0;
    for (int k = 0; k < 5; k++) begin
      edges(1);
      if (fire || dut.timer != 8'd0) early = 1'b1;
    end
    chk("intr hold_idle", early, 0);
    gstate = 4'd1;
    check_attempt("resume", rnd_col(F + 8 + F), used);

    // Random attempts against the model; aim alternates from reset.
    do_reset();
    n = 0;
    aim = 1'b1;
    for (int it = 0; it < 40; it++) begin
      playerX = 10'($urandom_range(0, 1023));
      enemy_offset = 10'($urandom_range(0, 1023));
      slot_busy = 3'($urandom_range(0, 6));
      for (int c = 0; c < 10; c++)
        enemy_status[c] = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      if ($urandom_range(0, 7) == 0) enemy_status = '0;
      check_attempt("rand", aim ? aim_col(playerX) : rnd_col(n + F), used);
      n += used;
      aim = ~aim;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
